counter_ctrl: RTL and testbench

//  Drives one 4-bit loadable up/down counter (74LS191-style pins: M, _LD, A..D in; Qa..Qd, _Qcc out).

---
 rtl/counter_ctrl_pkg.sv | 23 ++
 rtl/counter_ctrl_percnt.sv | 46 ++++
 rtl/counter_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_counter_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter_ctrl period controller: FSM state
// encodings, default parameters, direction constants and a state helper.
package counter_ctrl_pkg;

   localparam int PW_DEF       = 8;
   localparam int WD_LIMIT_DEF = 20;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_FIN  = 2'd3;

   // The controller owns the external counter while loading or running.
   function automatic logic is_busy_state(input state_t s);
      return (s == ST_LOAD) || (s == ST_RUN);
   endfunction

endpackage

// File: rtl/counter_ctrl_percnt.sv
// Period counter for counter_ctrl: PW-bit count of completed periods with
// synchronous clear and increment, plus a look-ahead terminal flag that is
// high when the next increment reaches a non-zero period target.
module counter_ctrl_percnt
   import counter_ctrl_pkg::*;
#(
   parameter int PW = PW_DEF
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          clear,
   input  logic          inc,
   input  logic [PW-1:0] nper,
   output logic [PW-1:0] pcnt,
   output logic          term
);

   logic [PW-1:0] pcnt_q;
   logic [PW-1:0] pcnt_d;
   logic [PW-1:0] pcnt_inc;

   // Wraps naturally at 2^PW-1 -> 0; a zero target never terminates.
   assign pcnt_inc = pcnt_q + PW'(1);
   assign term     = (nper != '0) && (pcnt_inc == nper);
   assign pcnt     = pcnt_q;

   // Next count: clear on a new run, otherwise step on each period event.
   always_comb begin
      pcnt_d = pcnt_q;
      if (clear) begin
         pcnt_d = '0;
      end else if (inc) begin
         pcnt_d = pcnt_inc;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (clr) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: drives a 74LS191-style 4-bit up/down counter as a
// programmable timer. Loads a preset, counts terminal (_Qcc) events as
// periods, reloads after each period and pulses DONE after NPER periods
// (NPER=0 runs until STOP). All outputs are registered.
// Optional checking is enabled by defining COUNTER_CTRL_CHECK_EN: the
// counter outputs are compared against the preset on the first RUN cycle
// after each load, and a watchdog flags a RUN that sees no _Qcc event
// within WD_LIMIT cycles. Either fault sets a sticky ERR and blocks START.
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int PW       = PW_DEF,
   parameter int WD_LIMIT = WD_LIMIT_DEF
) (
   input  logic          CP,
   input  logic          CLR,
   input  logic          START,
   input  logic          STOP,
   input  logic          DIR,
   input  logic [3:0]    PRESET,
   input  logic [PW-1:0] NPER,
   input  logic          Qa,
   input  logic          Qb,
   input  logic          Qc,
   input  logic          Qd,
   input  logic          _Qcc,
   output logic          M,
   output logic          _LD,
   output logic          A,
   output logic          B,
   output logic          C,
   output logic          D,
   output logic          BUSY,
   output logic          DONE,
   output logic [PW-1:0] PCNT,
   output logic          ERR
);

   state_t        state_q, state_d;
   logic          m_q, m_d;
   logic          ld_n_q, ld_n_d;
   logic [3:0]    data_q, data_d;
   logic [PW-1:0] nper_q, nper_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          pc_clear;
   logic          pc_inc;
   logic          pc_term;
   logic          err_set;
   logic          check_fault;
   logic          start_block;

   counter_ctrl_percnt #(
      .PW(PW)
   ) u_percnt (
      .clk  (CP),
      .clr  (CLR),
      .clear(pc_clear),
      .inc  (pc_inc),
      .nper (nper_q),
      .pcnt (PCNT),
      .term (pc_term)
   );

`ifdef COUNTER_CTRL_CHECK_EN
   localparam int WD_W = $clog2(WD_LIMIT + 1);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;
   logic            preset_bad;
   logic            wd_expire;

   // wd_q==0 marks the first RUN cycle after a load, when the counter
   // must be showing the preset it was just loaded with.
   assign preset_bad  = (wd_q == '0) && ({Qd, Qc, Qb, Qa} != data_q);
   assign wd_expire   = (wd_q == WD_W'(WD_LIMIT - 1));
   assign check_fault = (state_q == ST_RUN) && (preset_bad || (_Qcc && wd_expire));
   assign start_block = err_q;
   assign ERR         = err_q;

   // Watchdog: counts RUN cycles since the last load; any other state clears it.
   always_comb begin
      wd_d  = '0;
      err_d = err_q | err_set;
      if (state_q == ST_RUN) begin
         wd_d = wd_q + WD_W'(1);
      end
   end

   // Watchdog and sticky error registers.
   always_ff @(posedge CP) begin
      if (CLR) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end
`else
   logic unused_check_inputs;

   assign check_fault         = 1'b0;
   assign start_block         = 1'b0;
   assign ERR                 = 1'b0;
   assign unused_check_inputs = ^{Qa, Qb, Qc, Qd, err_set} ^ (WD_LIMIT > 0);
`endif

   // FSM next state, latched run setup and registered counter-pin values.
   always_comb begin
      state_d  = state_q;
      m_d      = m_q;
      data_d   = data_q;
      nper_d   = nper_q;
      pc_clear = 1'b0;
      pc_inc   = 1'b0;
      err_set  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (START && !start_block) begin
               state_d  = ST_LOAD;
               m_d      = DIR;
               data_d   = PRESET;
               nper_d   = NPER;
               pc_clear = 1'b1;
            end
         end
         ST_LOAD: begin
            state_d = STOP ? ST_IDLE : ST_RUN;
         end
         ST_RUN: begin
            // STOP outranks a coincident period event.
            if (STOP) begin
               state_d = ST_IDLE;
            end else if (check_fault) begin
               err_set = 1'b1;
               state_d = ST_IDLE;
            end else if (!_Qcc) begin
               pc_inc  = 1'b1;
               state_d = pc_term ? ST_FIN : ST_LOAD;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Pin values track the state being entered so they are valid for
      // the whole cycle spent in that state.
      ld_n_d = (state_d != ST_LOAD);
      busy_d = is_busy_state(state_d);
      done_d = (state_d == ST_FIN);
   end

   // Control and output registers.
   always_ff @(posedge CP) begin
      if (CLR) begin
         state_q <= ST_IDLE;
         m_q     <= DIR_UP;
         ld_n_q  <= 1'b1;
         data_q  <= 4'd0;
         nper_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         ld_n_q  <= ld_n_d;
         data_q  <= data_d;
         nper_q  <= nper_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign M    = m_q;
   assign _LD  = ld_n_q;
   assign A    = data_q[0];
   assign B    = data_q[1];
   assign C    = data_q[2];
   assign D    = data_q[3];
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl driving a behavioural 4-bit up/down
// counter (74LS191-style) on the same clock.
module tb_counter_ctrl;
   import counter_ctrl_pkg::*;

   localparam int PW = 8;

   logic          CP = 1'b0;
   logic          CLR, START, STOP, DIR;
   logic [3:0]    PRESET;
   logic [PW-1:0] NPER;
   logic          M, ld_n, A, B, C, D, BUSY, DONE, ERR;
   logic [PW-1:0] PCNT;
   logic          qcc_n;
   logic          force_hi;
   logic [3:0]    cq = 4'd0;

   int total = 0;
   int bad   = 0;
   int n_ld, n_done, n_qcc, n_mbad;
   logic exp_m;

   always #5 CP = ~CP;

   // Counter model: parallel load on _LD low, else count in direction M.
   always @(posedge CP) begin
      if (ld_n === 1'b0) cq <= {D, C, B, A};
      else if (M === 1'b1) cq <= cq + 4'd1;
      else cq <= cq - 4'd1;
   end

   assign qcc_n = force_hi | ~((M === 1'b1) ? (cq == 4'hF) : (cq == 4'h0));

   counter_ctrl #(.PW(PW), .WD_LIMIT(20)) dut (
      .CP(CP), .CLR(CLR), .START(START), .STOP(STOP), .DIR(DIR),
      .PRESET(PRESET), .NPER(NPER),
      .Qa(cq[0]), .Qb(cq[1]), .Qc(cq[2]), .Qd(cq[3]), ._Qcc(qcc_n),
      .M(M), ._LD(ld_n), .A(A), .B(B), .C(C), .D(D),
      .BUSY(BUSY), .DONE(DONE), .PCNT(PCNT), .ERR(ERR)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic record();
      if (ld_n === 1'b0) n_ld++;
      if (DONE === 1'b1) n_done++;
      if (BUSY === 1'b1 && ld_n === 1'b1 && qcc_n === 1'b0) n_qcc++;
      if (BUSY === 1'b1 && M !== exp_m) n_mbad++;
   endtask

   task automatic step();
      @(posedge CP);
      #1;
      record();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic start_run(input logic dir, input logic [3:0] pre, input logic [PW-1:0] np);
      DIR    = dir;
      PRESET = pre;
      NPER   = np;
      exp_m  = dir;
      n_ld = 0; n_done = 0; n_qcc = 0; n_mbad = 0;
      START  = 1'b1;
      step();
      START  = 1'b0;
   endtask

   initial begin
      CLR = 1'b1; START = 1'b0; STOP = 1'b0; DIR = 1'b1;
      PRESET = 4'd0; NPER = '0; force_hi = 1'b0; exp_m = 1'b1;
      n_ld = 0; n_done = 0; n_qcc = 0; n_mbad = 0;
      steps(2);
      check("rst_ld", 32'(ld_n), 1);
      check("rst_m", 32'(M), 1);
      check("rst_data", 32'({D, C, B, A}), 0);
      check("rst_busy", 32'(BUSY), 0);
      check("rst_pcnt", 32'(PCNT), 0);
      CLR = 1'b0;
      step();

      // 1: reset while running
      start_run(DIR_DN, 4'd1, 8'd0);
      steps(4);
      check("t1_busy_pre", 32'(BUSY), 1);
      check("t1_pcnt_pre", 32'(PCNT), 1);
      check("t1_m_pre", 32'(M), 0);
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      check("t1_ld", 32'(ld_n), 1);
      check("t1_m", 32'(M), 1);
      check("t1_busy", 32'(BUSY), 0);
      check("t1_pcnt", 32'(PCNT), 0);
      check("t1_done", 32'(DONE), 0);
      step();
      check("t1_stay_idle", 32'(BUSY), 0);

      // 2: count up from 13, two periods
      start_run(DIR_UP, 4'd13, 8'd2);
      check("t2_ld_first", 32'(ld_n), 0);
      check("t2_data", 32'({D, C, B, A}), 13);
      steps(7);
      check("t2_done_early", 32'(DONE), 0);
      check("t2_busy_run", 32'(BUSY), 1);
      step();
      check("t2_done", 32'(DONE), 1);
      check("t2_pcnt", 32'(PCNT), 2);
      check("t2_busy_fin", 32'(BUSY), 0);
      step();
      check("t2_done_pulse", 32'(DONE), 0);
      steps(3);
      check("t2_n_ld", 32'(n_ld), 2);
      check("t2_n_qcc", 32'(n_qcc), 2);
      check("t2_n_done", 32'(n_done), 1);
      check("t2_m_bad", 32'(n_mbad), 0);

      // 3: count down from 2, three periods
      start_run(DIR_DN, 4'd2, 8'd3);
      steps(11);
      check("t3_busy_run", 32'(BUSY), 1);
      check("t3_done_early", 32'(DONE), 0);
      step();
      check("t3_done", 32'(DONE), 1);
      check("t3_pcnt", 32'(PCNT), 3);
      check("t3_m_held", 32'(M), 0);
      step();
      check("t3_done_pulse", 32'(DONE), 0);
      steps(2);
      check("t3_n_ld", 32'(n_ld), 3);
      check("t3_n_qcc", 32'(n_qcc), 3);
      check("t3_n_done", 32'(n_done), 1);
      check("t3_m_bad", 32'(n_mbad), 0);

      // 4: free-run aborted after five periods
      start_run(DIR_UP, 4'd14, 8'd0);
      steps(15);
      check("t4_pcnt_5", 32'(PCNT), 5);
      check("t4_reload", 32'(ld_n), 0);
      STOP = 1'b1;
      step();
      STOP = 1'b0;
      check("t4_busy", 32'(BUSY), 0);
      check("t4_ld", 32'(ld_n), 1);
      steps(4);
      check("t4_pcnt_hold", 32'(PCNT), 5);
      check("t4_n_ld", 32'(n_ld), 6);
      check("t4_n_done", 32'(n_done), 0);

      // 5: START ignored in RUN, STOP beats a coincident period event
      start_run(DIR_UP, 4'd14, 8'd4);
      steps(4);
      check("t5_pcnt_1", 32'(PCNT), 1);
      START = 1'b1;
      PRESET = 4'd3;
      step();
      check("t5_start_ign", 32'(ld_n), 1);
      check("t5_busy", 32'(BUSY), 1);
      check("t5_qcc_low", 32'(qcc_n), 0);
      START = 1'b0;
      STOP  = 1'b1;
      step();
      STOP  = 1'b0;
      check("t5_idle", 32'(BUSY), 0);
      check("t5_pcnt", 32'(PCNT), 1);
      steps(3);
      check("t5_pcnt_hold", 32'(PCNT), 1);
      check("t5_n_done", 32'(n_done), 0);

      // 6: stuck carry
      force_hi = 1'b1;
      start_run(DIR_UP, 4'd3, 8'd0);
`ifdef COUNTER_CTRL_CHECK_EN
      steps(20);
      check("t6_err_early", 32'(ERR), 0);
      check("t6_busy_early", 32'(BUSY), 1);
      step();
      check("t6_err", 32'(ERR), 1);
      check("t6_busy", 32'(BUSY), 0);
      START = 1'b1;
      steps(2);
      START = 1'b0;
      check("t6_start_blk", 32'(BUSY), 0);
      check("t6_err_sticky", 32'(ERR), 1);
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      check("t6_err_clr", 32'(ERR), 0);
      force_hi = 1'b0;
      start_run(DIR_UP, 4'd3, 8'd0);
      check("t6_restart", 32'(BUSY), 1);
`else
      steps(25);
      check("t6_err_tied", 32'(ERR), 0);
      check("t6_still_run", 32'(BUSY), 1);
      force_hi = 1'b0;
`endif
      STOP = 1'b1;
      step();
      STOP = 1'b0;
      check("t6_stopped", 32'(BUSY), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
